// File: rtl/render_pkg.sv
// Shared types and constants for the sprite compositor: colours, the per-sprite
// register set and an elaboration-time ceil(log2) helper.
package render_pkg;

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'h0000FF;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
        logic       flip;
    } spr_reg_t;

    // Never returns less than 1 so a single-entry ROM still gets a real port.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/sprite_regfile.sv
// Double-buffered sprite registers: writes land in the shadow set, frame_start
// commits every shadow set to the active set at once.
module sprite_regfile
    import render_pkg::*;
#(
    parameter int NUM_SPR = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [2:0]             wr_idx,
    input  logic [9:0]             wr_x,
    input  logic [9:0]             wr_y,
    input  logic                   wr_vis,
    input  logic                   wr_flip,
    input  logic                   commit,
    output spr_reg_t [NUM_SPR-1:0] active
);

    spr_reg_t [NUM_SPR-1:0] shadow;
    spr_reg_t [NUM_SPR-1:0] shadow_nxt;

    // Indices at or above NUM_SPR match no entry, so such writes fall away.
    always_comb begin
        shadow_nxt = shadow;
        if (wr_en) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                if (int'(wr_idx) == i) begin
                    shadow_nxt[i].x    = wr_x;
                    shadow_nxt[i].y    = wr_y;
                    shadow_nxt[i].vis  = wr_vis;
                    shadow_nxt[i].flip = wr_flip;
                end
            end
        end
    end

    // Committing shadow_nxt lets a write in the frame_start cycle take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (commit) begin
                active <= shadow_nxt;
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: hit/priority and ROM address in stage 1, flags delayed to
// meet ROM data, then border / sprite / background colour selection.
module sprite_compositor
    import render_pkg::*;
#(
    parameter int          NUM_SPR  = 4,
    parameter int          SPR_W    = 75,
    parameter int          SPR_H    = 137,
    parameter int          SCREEN_W = 800,
    parameter int          BORDER   = 40,
    parameter int          ROM_LAT  = 1,
    parameter logic [23:0] KEY      = 24'hFF00FF,
    localparam int         ADDR_W   = clog2(NUM_SPR * SPR_W * SPR_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic              pos_wr_en,
    input  logic [2:0]        pos_wr_idx,
    input  logic [9:0]        pos_wr_x,
    input  logic [9:0]        pos_wr_y,
    input  logic              pos_wr_vis,
    input  logic              pos_wr_flip,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_q,
    output logic [23:0]       vga_data,
    output logic              out_valid
);

    spr_reg_t [NUM_SPR-1:0] active;

    sprite_regfile #(
        .NUM_SPR (NUM_SPR)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pos_wr_en),
        .wr_idx  (pos_wr_idx),
        .wr_x    (pos_wr_x),
        .wr_y    (pos_wr_y),
        .wr_vis  (pos_wr_vis),
        .wr_flip (pos_wr_flip),
        .commit  (frame_start),
        .active  (active)
    );

    // 11-bit bounds so a sprite hanging past 1023 cannot wrap back to the left.
    logic [NUM_SPR-1:0] hit_vec;
    always_comb begin
        hit_vec = '0;
        for (int s = 0; s < NUM_SPR; s++) begin
            hit_vec[s] = active[s].vis
                && ({1'b0, pix_x} >= {1'b0, active[s].x})
                && ({1'b0, pix_x} <  ({1'b0, active[s].x} + 11'(SPR_W)))
                && ({1'b0, pix_y} >= {1'b0, active[s].y})
                && ({1'b0, pix_y} <  ({1'b0, active[s].y} + 11'(SPR_H)));
        end
    end

    logic       hit;
    logic [2:0] win_idx;
    spr_reg_t   win;
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        win     = '0;
        for (int s = NUM_SPR - 1; s >= 0; s--) begin
            if (hit_vec[s]) begin
                hit     = 1'b1;
                win_idx = 3'(s);
                win     = active[s];
            end
        end
    end

    logic [9:0]  col;
    logic [9:0]  dy;
    logic [9:0]  row;
    logic [31:0] addr_full;
    always_comb begin
        col       = pix_x - win.x;
        dy        = pix_y - win.y;
        row       = win.flip ? (10'(SPR_H - 1) - dy) : dy;
        addr_full = 32'(win_idx) * 32'(SPR_W * SPR_H)
                  + 32'(row) * 32'(SPR_W)
                  + 32'(col);
    end

    logic fetch;
    logic border;
    assign fetch  = pix_valid & hit;
    assign border = (32'(pix_x) < 32'(BORDER)) || (32'(pix_x) >= 32'(SCREEN_W - BORDER));

    // Bit 0 is the stage-1 copy; bit ROM_LAT lines up with rom_q.
    logic [ROM_LAT:0] dly_valid;
    logic [ROM_LAT:0] dly_hit;
    logic [ROM_LAT:0] dly_border;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            dly_valid  <= '0;
            dly_hit    <= '0;
            dly_border <= '0;
        end else begin
            rom_addr   <= fetch ? ADDR_W'(addr_full) : '0;
            dly_valid  <= {dly_valid[ROM_LAT-1:0], pix_valid};
            dly_hit    <= {dly_hit[ROM_LAT-1:0], fetch};
            dly_border <= {dly_border[ROM_LAT-1:0], border};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_data  <= BLACK;
            out_valid <= 1'b0;
        end else begin
            out_valid <= dly_valid[ROM_LAT];
            if (!dly_valid[ROM_LAT]) begin
                vga_data <= BLACK;
            end else if (dly_border[ROM_LAT]) begin
                vga_data <= RED;
            end else if (dly_hit[ROM_LAT] && (rom_q != KEY)) begin
                vga_data <= rom_q;
            end else begin
                vga_data <= WHITE;
            end
        end
    end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_SPR, default 4: sprite channel count, legal range 1..8.
REQ-002 Parameter SPR_W, default 75: sprite width in pixels.
REQ-003 Parameter SPR_H, default 137: sprite height in pixels.
REQ-004 Parameter SCREEN_W, default 800: visible width in pixels.
REQ-005 Parameter BORDER, default 40: width of the left and right border bands.
REQ-006 Parameter ROM_LAT, default 1: fixed ROM read latency in cycles, legal range 1..3.
REQ-007 Parameter KEY, default 24'hFF00FF: transparent colour key.
REQ-008 Reset rst_n is asynchronous and active-low; the clock is clk.
REQ-009 Port clk, input, 1 bit: pixel clock.
REQ-010 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-011 Port pix_x and pix_y, input, 10 bits each: coordinate of the current pixel.
REQ-012 Port pix_valid, input, 1 bit: the coordinate is inside the visible area.
REQ-013 Port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-014 Port pos_wr_en, input, 1 bit: write strobe for a sprite register.
REQ-015 Port pos_wr_idx, input, 3 bits: index of the sprite to write.
REQ-016 Port pos_wr_x and pos_wr_y, input, 10 bits each: sprite top-left position.
REQ-017 Port pos_wr_vis, input, 1 bit: sprite visible flag.
REQ-018 Port pos_wr_flip, input, 1 bit: vertical mirror flag.
REQ-019 Port rom_addr, output, ADDR_W = clog2(NUM_SPR*SPR_W*SPR_H) bits: bitmap ROM address.
REQ-020 Port rom_q, input, 24 bits: ROM data, valid ROM_LAT cycles after rom_addr.
REQ-021 Port vga_data, output, 24 bits: composited pixel colour.
REQ-022 Port out_valid, output, 1 bit: vga_data corresponds to a pixel.

Function
REQ-023 Each sprite SHALL have a shadow register set {x, y, vis, flip} and an active register set.
- pos_wr_en writes the shadow set of sprite pos_wr_idx.
- A write with pos_wr_idx >= NUM_SPR is ignored.
REQ-024 frame_start SHALL copy every shadow set to its active set in one cycle.
- When pos_wr_en and frame_start occur in the same cycle, the newly written value is the one committed.
REQ-025 Sprite s SHALL hit when its active vis is 1, x <= pix_x < x+SPR_W and y <= pix_y < y+SPR_H.
- The comparisons are done in 11 bits, so a sprite extending past coordinate 1023 never wraps.
REQ-026 Among hitting sprites, the lowest index SHALL win; exactly one ROM fetch is made per pixel.
REQ-027 For the winning sprite, row = pix_y-y, or SPR_H-1-(pix_y-y) when flip=1, and col = pix_x-x.
- rom_addr = s*SPR_W*SPR_H + row*SPR_W + col.
REQ-028 Pipeline stage 1 SHALL register the inputs and compute the hit and priority; rom_addr is registered at the end of stage 1.
REQ-029 The border flag, the hit flag and pix_valid SHALL be delayed ROM_LAT cycles so that they align with rom_q.
REQ-030 The output register SHALL select colours in this priority order:
- border (pix_x < BORDER or pix_x >= SCREEN_W-BORDER): RED 24'h0000FF;
- otherwise a hit with rom_q != KEY: rom_q;
- otherwise: WHITE 24'hFFFFFF.
- Lower-priority sprites are not shown behind a keyed pixel.
REQ-031 Latency from pix_valid to out_valid SHALL be exactly ROM_LAT+2 cycles, with throughput of one pixel per cycle and no stalls.
REQ-032 When out_valid=0, vga_data SHALL be BLACK 24'h000000.
REQ-033 rom_addr SHALL hold 0 for pixels with no sprite hit.

Reset
REQ-034 While rst_n=0, all shadow and active sets SHALL clear to x=0, y=0, vis=0, flip=0.
REQ-035 While rst_n=0, all pipeline valids, vga_data and rom_addr SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL flush the pipeline, with no valid output for ROM_LAT+2 cycles after release.

Structure
REQ-037 Package render_pkg SHALL hold the colour constants, the sprite register struct typedef and the clog2 function.
REQ-038 Sub-module sprite_regfile SHALL implement the shadow/active registers and the commit logic; sprite_compositor instantiates it once.

Verification
REQ-039 Sprite 0 at (100,200), vis=1, frame_start, pixel (100,200) -> rom_addr=0 one cycle later; vga_data=rom_q and out_valid=1 after ROM_LAT+2 cycles.
REQ-040 Sprites 0 and 1 both cover (150,250) -> the sprite 0 address is fetched; sprite 1 is never addressed.
REQ-041 Sprite 1 with flip=1 at (300,0), pixel (300,0) -> rom_addr = 1*10275 + 136*75 = 20475.
REQ-042 rom_q=KEY on a hit -> WHITE; pixel x=20 or x=770 -> RED regardless of sprites.
REQ-043 A write to x=400 mid-frame -> the old position remains in effect until frame_start; a write in the same cycle as frame_start -> active x=400 immediately; a write with idx=7 when NUM_SPR=4 -> no change.
REQ-044 rst_n pulsed during a pixel stream -> out_valid=0 and vga_data=BLACK until ROM_LAT+2 cycles after release; all sprites invisible afterwards.
